// File: rtl/grid_pkg.sv
// Shared constants and types for the game-grid memory arbiter.
// Cell codes, sweeper state encoding and the {y, x} address packing helper.
package grid_pkg;

  localparam int GRID_BITS = 4;
  localparam int DATA_W    = 2;
  localparam int ADDR_W    = 2 * GRID_BITS;

  typedef enum logic [DATA_W-1:0] {
    EMPTY = 2'd0,
    SNAKE = 2'd1,
    FOOD  = 2'd2,
    WALL  = 2'd3
  } cell_e;

  localparam logic [DATA_W-1:0] CLEAR_VALUE = EMPTY;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } sweep_state_e;

  function automatic logic [ADDR_W-1:0] pack_addr(input logic [GRID_BITS-1:0] x,
                                                  input logic [GRID_BITS-1:0] y);
    return {y, x};
  endfunction

endpackage

// File: rtl/grid_mem_arbiter_if.sv
// Requester and RAM-side signals of the grid arbiter.
// The arbiter uses the slave modport; requesters and the RAM model use master.
interface grid_mem_arbiter_if;
  import grid_pkg::*;

  logic                 vga_req;
  logic [GRID_BITS-1:0] vga_x;
  logic [GRID_BITS-1:0] vga_y;
  logic                 vga_valid;
  logic [DATA_W-1:0]    vga_data;

  logic                 sw_req;
  logic [GRID_BITS-1:0] sw_x;
  logic [GRID_BITS-1:0] sw_y;
  logic [DATA_W-1:0]    sw_data;
  logic                 sw_gnt;

  logic                 clr_start;
  logic                 clr_busy;
  logic                 clr_done;

  logic                 mem_en;
  logic                 mem_we;
  logic [ADDR_W-1:0]    mem_addr;
  logic [DATA_W-1:0]    mem_wdata;
  logic [DATA_W-1:0]    mem_rdata;

  modport master (
    output vga_req, vga_x, vga_y, sw_req, sw_x, sw_y, sw_data, clr_start, mem_rdata,
    input  vga_valid, vga_data, sw_gnt, clr_busy, clr_done,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  vga_req, vga_x, vga_y, sw_req, sw_x, sw_y, sw_data, clr_start, mem_rdata,
    output vga_valid, vga_data, sw_gnt, clr_busy, clr_done,
           mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/grid_clear_sweeper.sv
// Full-board clear sequencer: walks clr_addr from 0 to all-ones, one write per
// unstalled cycle, then pulses clr_done.
//   state | meaning
//   IDLE  | no sweep; clr_start launches one from address 0
//   SWEEP | writing CLEAR_VALUE at clr_addr on every cycle without stall
module grid_clear_sweeper
  import grid_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_start_i,
  input  logic              stall_i,
  output logic              clr_busy_o,
  output logic              clr_done_o,
  output logic              clr_we_o,
  output logic [ADDR_W-1:0] clr_addr_o
);

  sweep_state_e      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              done_q, done_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
    end
  end

  // The counter naturally wraps back to 0 on the final increment.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (clr_start_i) begin
          state_d = SWEEP;
          addr_d  = '0;
        end
      end
      SWEEP: begin
        if (!stall_i) begin
          addr_d = addr_q + ADDR_W'(1);
          if (addr_q == '1) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    clr_busy_o = (state_q == SWEEP);
    clr_we_o   = (state_q == SWEEP) && !stall_i;
  end

  assign clr_addr_o = addr_q;
  assign clr_done_o = done_q;

endmodule

// File: rtl/grid_mem_arbiter.sv
// Single-port grid RAM arbiter: VGA read > clear sweep > snake write, with a
// two-cycle registered read return to the VGA fetch.
module grid_mem_arbiter
  import grid_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  grid_mem_arbiter_if.slave  bus
);

  logic              clr_we;
  logic              clr_busy;
  logic              clr_done;
  logic [ADDR_W-1:0] clr_addr;

  logic              rd_pend_q;
  logic              vga_valid_q;
  logic [DATA_W-1:0] vga_data_q;

  logic              sw_gnt;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  grid_clear_sweeper u_sweeper (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clr_start_i (bus.clr_start),
    .stall_i     (bus.vga_req),
    .clr_busy_o  (clr_busy),
    .clr_done_o  (clr_done),
    .clr_we_o    (clr_we),
    .clr_addr_o  (clr_addr)
  );

  // RAM returns data the cycle after the request; it is captured one cycle later.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_pend_q   <= 1'b0;
      vga_valid_q <= 1'b0;
      vga_data_q  <= '0;
    end else begin
      rd_pend_q   <= bus.vga_req;
      vga_valid_q <= rd_pend_q;
      if (rd_pend_q) begin
        vga_data_q <= bus.mem_rdata;
      end
    end
  end

  // Gating with rst_ni keeps the combinational outputs quiet while in reset.
  always_comb begin
    sw_gnt    = rst_ni && bus.sw_req && !bus.vga_req && !clr_busy;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (rst_ni) begin
      if (bus.vga_req) begin
        mem_en   = 1'b1;
        mem_addr = pack_addr(bus.vga_x, bus.vga_y);
      end else if (clr_we) begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = clr_addr;
        mem_wdata = CLEAR_VALUE;
      end else if (sw_gnt) begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = pack_addr(bus.sw_x, bus.sw_y);
        mem_wdata = bus.sw_data;
      end
    end
  end

  assign bus.vga_valid = vga_valid_q;
  assign bus.vga_data  = vga_data_q;
  assign bus.sw_gnt    = sw_gnt;
  assign bus.clr_busy  = clr_busy;
  assign bus.clr_done  = clr_done;
  assign bus.mem_en    = mem_en;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;

endmodule

// File: tb/tb_grid_mem_arbiter.sv
// Scoreboard bench for grid_mem_arbiter: expected RAM writes and VGA read
// returns are queued by the stimulus and consumed by a negedge monitor.
module tb_grid_mem_arbiter;
  import grid_pkg::*;

  typedef struct {
    logic [7:0] addr;
    logic [1:0] data;
  } wr_t;

  typedef struct {
    logic [1:0] data;
    int         due;
  } rd_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  grid_mem_arbiter_if bus ();

  grid_mem_arbiter dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  logic [1:0] ram [256];
  logic [1:0] ram_rdata = 2'b00;
  logic [1:0] shadow [256];

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            ram_rdata <= ram[bus.mem_addr];
    end
  end
  assign bus.mem_rdata = ram_rdata;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  wr_t wq[$];
  rd_t rq[$];
  int  checks = 0;
  int  failures = 0;
  int  busy_cnt = 0;
  int  done_cnt = 0;
  int  vga_in_busy = 0;
  int  last_done_cyc = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: consumes expected writes/reads whenever the DUT presents one.
  initial begin
    wr_t e;
    rd_t r;
    for (int i = 0; i < 256; i++) shadow[i] = 2'b00;
    forever begin
      @(negedge clk);
      if (bus.mem_en && bus.mem_we) begin
        if (wq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL wr_unexpected addr=%0h data=%0h required=no write", bus.mem_addr, bus.mem_wdata);
        end else begin
          e = wq.pop_front();
          chk("wr_addr", 32'(bus.mem_addr), 32'(e.addr));
          chk("wr_data", 32'(bus.mem_wdata), 32'(e.data));
          shadow[e.addr] = e.data;
        end
      end
      if (bus.vga_valid) begin
        if (rq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rd_unexpected data=%0h required=no valid", bus.vga_data);
        end else begin
          r = rq.pop_front();
          chk("rd_data", 32'(bus.vga_data), 32'(r.data));
          chk("rd_latency_cycle", 32'(cyc), 32'(r.due));
        end
      end
      if (bus.clr_busy && bus.sw_req) chk("sw_gnt_in_sweep", 32'(bus.sw_gnt), 32'd0);
      if (bus.clr_busy) busy_cnt++;
      if (bus.clr_busy && bus.vga_req) vga_in_busy++;
      if (bus.clr_done) begin
        done_cnt++;
        last_done_cyc = cyc;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic vga_read(input logic [7:0] a);
    bus.vga_req = 1'b1;
    bus.vga_x   = a[3:0];
    bus.vga_y   = a[7:4];
    rq.push_back('{data: shadow[a], due: cyc + 2});
  endtask

  task automatic snake_drive(input logic [7:0] a, input logic [1:0] d);
    bus.sw_req  = 1'b1;
    bus.sw_x    = a[3:0];
    bus.sw_y    = a[7:4];
    bus.sw_data = d;
  endtask

  task automatic push_clears();
    for (int i = 0; i < 256; i++) wq.push_back('{addr: 8'(i), data: 2'b00});
  endtask

  initial begin
    int start;
    int gnt_cyc;
    logic [7:0] a8;
    bus.vga_req = 0; bus.vga_x = 0; bus.vga_y = 0;
    bus.sw_req = 0; bus.sw_x = 0; bus.sw_y = 0; bus.sw_data = 0;
    bus.clr_start = 0;

    repeat (2) step();
    @(negedge clk);
    chk("rst_vga_valid", 32'(bus.vga_valid), 0);
    chk("rst_vga_data", 32'(bus.vga_data), 0);
    chk("rst_clr_busy", 32'(bus.clr_busy), 0);
    chk("rst_clr_done", 32'(bus.clr_done), 0);
    chk("rst_mem_en", 32'(bus.mem_en), 0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 0);
    rst_n = 1'b1;

    // Preload 0x53 = FOOD, then VGA read of (x=3, y=5).
    step();
    snake_drive(8'h53, 2'b10);
    wq.push_back('{addr: 8'h53, data: 2'b10});
    @(negedge clk);
    chk("t1_preload_gnt", 32'(bus.sw_gnt), 1);
    step();
    bus.sw_req = 0;
    vga_read(8'h53);
    @(negedge clk);
    chk("t1_mem_addr", 32'(bus.mem_addr), 32'h53);
    chk("t1_mem_en", 32'(bus.mem_en), 1);
    chk("t1_mem_we", 32'(bus.mem_we), 0);
    step();
    bus.vga_req = 0;
    @(negedge clk);
    chk("t1_valid_t1", 32'(bus.vga_valid), 0);
    step();
    @(negedge clk);
    chk("t1_valid_t2", 32'(bus.vga_valid), 1);
    chk("t1_data_t2", 32'(bus.vga_data), 32'h2);

    // Snake write at (7,2) blocked by three VGA cycles.
    step();
    snake_drive(8'h27, 2'b01);
    for (int i = 0; i < 3; i++) begin
      vga_read(8'(i));
      @(negedge clk);
      chk("t2_gnt_blocked", 32'(bus.sw_gnt), 0);
      step();
    end
    bus.vga_req = 0;
    wq.push_back('{addr: 8'h27, data: 2'b01});
    @(negedge clk);
    chk("t2_gnt_4th", 32'(bus.sw_gnt), 1);
    chk("t2_wr_addr", 32'(bus.mem_addr), 32'h27);
    step();
    bus.sw_req = 0;
    repeat (3) step();

    // Unobstructed clear sweep, then full read-back.
    busy_cnt = 0; done_cnt = 0;
    bus.clr_start = 1;
    push_clears();
    start = cyc;
    step();
    bus.clr_start = 0;
    for (int k = 0; k < 400 && done_cnt == 0; k++) step();
    chk("t3_busy_cycles", 32'(busy_cnt), 256);
    chk("t3_done_count", 32'(done_cnt), 1);
    chk("t3_done_cycle", 32'(last_done_cyc), 32'(start + 257));
    for (int a = 0; a < 256; a++) begin
      vga_read(8'(a));
      step();
    end
    bus.vga_req = 0;
    repeat (3) step();
    chk("t3_wq_empty", 32'(wq.size()), 0);
    chk("t3_rq_empty", 32'(rq.size()), 0);

    // Fill with a pattern, then sweep with a VGA read every 4th cycle.
    for (int a = 0; a < 256; a++) begin
      a8 = 8'(a);
      snake_drive(a8, a8[1:0] ^ a8[5:4]);
      wq.push_back('{addr: a8, data: a8[1:0] ^ a8[5:4]});
      step();
    end
    bus.sw_req = 0;
    busy_cnt = 0; done_cnt = 0; vga_in_busy = 0;
    bus.clr_start = 1;
    push_clears();
    for (int k = 1; k < 500; k++) begin
      step();
      bus.clr_start = (k == 100);
      if (k % 4 == 0) vga_read(8'((k * 37) % 256));
      else bus.vga_req = 0;
      @(negedge clk);
      if (done_cnt != 0) break;
    end
    step();
    bus.vga_req = 0;
    bus.clr_start = 0;
    repeat (3) step();
    chk("t4_busy_cycles", 32'(busy_cnt), 341);
    chk("t4_vga_in_sweep", 32'(vga_in_busy), 85);
    chk("t4_done_count", 32'(done_cnt), 1);
    chk("t4_wq_empty", 32'(wq.size()), 0);
    chk("t4_rq_empty", 32'(rq.size()), 0);

    // Snake request held across a whole sweep.
    done_cnt = 0;
    bus.clr_start = 1;
    push_clears();
    wq.push_back('{addr: 8'h11, data: 2'b11});
    start = cyc;
    gnt_cyc = -1;
    step();
    bus.clr_start = 0;
    snake_drive(8'h11, 2'b11);
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (bus.sw_gnt) begin
        gnt_cyc = cyc;
        chk("t5_done_with_gnt", 32'(bus.clr_done), 1);
        break;
      end
      step();
    end
    chk("t5_gnt_cycle", 32'(gnt_cyc), 32'(start + 257));
    step();
    bus.sw_req = 0;
    repeat (2) step();
    chk("t5_wq_empty", 32'(wq.size()), 0);

    // Reset asserted when the sweep reaches 0x40.
    bus.clr_start = 1;
    push_clears();
    step();
    bus.clr_start = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.mem_we && bus.mem_addr == 8'h40) break;
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_clr_busy", 32'(bus.clr_busy), 0);
    chk("t6_clr_done", 32'(bus.clr_done), 0);
    chk("t6_vga_valid", 32'(bus.vga_valid), 0);
    chk("t6_vga_data", 32'(bus.vga_data), 0);
    chk("t6_sw_gnt", 32'(bus.sw_gnt), 0);
    chk("t6_mem_en", 32'(bus.mem_en), 0);
    chk("t6_mem_we", 32'(bus.mem_we), 0);
    chk("t6_mem_addr", 32'(bus.mem_addr), 0);
    chk("t6_mem_wdata", 32'(bus.mem_wdata), 0);
    chk("t6_remaining_writes", 32'(wq.size()), 191);
    wq.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0; busy_cnt = 0;
    repeat (300) step();
    chk("t6_no_done", 32'(done_cnt), 0);
    chk("t6_no_busy", 32'(busy_cnt), 0);
    chk("t6_idle_busy", 32'(bus.clr_busy), 0);

    chk("end_wq_empty", 32'(wq.size()), 0);
    chk("end_rq_empty", 32'(rq.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/grid_mem_arbiter.md
# grid_mem_arbiter

Sequences every access to the single-port 16x16 game-grid memory, which holds one 2-bit cell code per cell. It sits between the grid RAM and three requesters: the VGA pixel fetch (read), the snake writer (write), and an internal clear sweeper that blanks the board on a game reset. The arbiter also converts (x, y) locations into flat RAM addresses and returns read data with a fixed latency.

## Interface
- GRID_BITS, 4, bits per coordinate (grid is 2^GRID_BITS square)
- DATA_W, 2, cell code width
- CLEAR_VALUE, 2'b00, code written by the sweeper (EMPTY)
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- vga_req  in  1  VGA read request, sampled every cycle
- vga_x, vga_y  in  GRID_BITS each  VGA cell location
- vga_valid  out  1  vga_data updated this cycle
- vga_data  out  DATA_W  registered read data, held between valids
- sw_req  in  1  snake write request, held until granted
- sw_x, sw_y  in  GRID_BITS each  write location
- sw_data  in  DATA_W  write data
- sw_gnt  out  1  combinational grant; write occurs this cycle
- clr_start  in  1  single-cycle pulse that starts a full-board clear
- clr_busy  out  1  sweep in progress
- clr_done  out  1  one-cycle pulse after the last cell is written
- mem_en, mem_we  out  1 each  RAM enable / write enable
- mem_addr  out  2*GRID_BITS  {y, x}
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, one cycle after mem_en && !mem_we

## Operation
- Fixed priority per cycle: VGA read > sweeper write > snake write. Exactly one access or none per cycle.
- VGA: when vga_req=1, the arbiter drives mem_en=1, mem_we=0, mem_addr={vga_y,vga_x}. mem_rdata is registered into vga_data, and vga_valid pulses 2 cycles after the request.
- Snake: sw_gnt = sw_req & !vga_req & state==IDLE. On a grant, the arbiter drives mem_we=1, {sw_y,sw_x} as the address, and sw_data as write data. The requester holds its request until it sees sw_gnt.
- Sweeper FSM has two states, IDLE and SWEEP, with an address counter clr_addr of width 2*GRID_BITS.
  - IDLE -> SWEEP when clr_start=1; clr_addr is set to 0.
  - SWEEP: in each cycle without vga_req, the arbiter writes CLEAR_VALUE at clr_addr and increments clr_addr. Cycles with vga_req=1 stall the counter.
  - SWEEP -> IDLE after the write at clr_addr = all-ones. clr_done pulses in the following cycle.
- clr_start while in SWEEP is ignored; the sweep does not restart.
- clr_start and a granted sw_req in the same IDLE cycle: the snake write completes that cycle and the sweep begins on the next cycle. The sweep therefore erases that write, which is the intended behaviour.
- sw_gnt=0 for the whole duration of SWEEP.
- Address arithmetic: {y,x} concatenation with no bounds checking. clr_addr wraps only at exit.

## Timing
- Reset values: vga_valid=0, vga_data=0, sw_gnt=0, clr_busy=0, clr_done=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0. State is IDLE and clr_addr=0.
- Reset asserted mid-sweep: the arbiter returns to IDLE immediately. No clr_done is issued, and the sweep is not resumed.
- clr_busy is registered and is 1 from the cycle after clr_start until the cycle of the final write, inclusive.
- Minimum sweep duration is 256 cycles. It grows by 1 cycle for each vga_req cycle that falls inside the sweep.
- Read pipeline: request at cycle t, RAM read data at t+1, vga_data/vga_valid at t+2. Back-to-back requests sustain one result per cycle.
- All mem_* outputs are combinational from the current requests and state. vga_data, vga_valid, clr_busy and clr_done are registered.

## Structure
- Package grid_pkg: GRID_BITS, DATA_W, cell codes (EMPTY=0, SNAKE=1, FOOD=2, WALL=3), CLEAR_VALUE=EMPTY, sweeper state enum {IDLE, SWEEP}.
- Sub-module grid_clear_sweeper: FSM plus clr_addr counter. Inputs are clr_start and stall (=vga_req). Outputs are clr_busy, clr_done, clr_we and clr_addr.
- Top level: priority mux, address packing and the read-return pipeline.

## Test plan
- VGA read of (3,5) with RAM preloaded 2'b10 at address 0x53 -> mem_addr=0x53 at t, vga_valid=1 and vga_data=2'b10 at t+2.
- sw_req (7,2) data 2'b01 concurrent with vga_req for 3 cycles -> sw_gnt=0 for 3 cycles, then a write to 0x27 with sw_gnt=1 on the 4th cycle.
- clr_start pulse, no VGA traffic -> 256 writes of 2'b00 to addresses 0x00..0xFF in order, clr_busy high for 256 cycles, clr_done pulse once, all RAM cells read back 0.
- clr_start, then vga_req on every 4th cycle -> sweep takes 256 + (number of VGA cycles) cycles, no address is skipped or repeated, and VGA data is returned correctly throughout.
- sw_req held during SWEEP -> sw_gnt stays 0 until the cycle after the final clear write, then the write is granted.
- reset driven low at sweep address 0x40 -> all outputs go to their reset values asynchronously. After release, IDLE with clr_busy=0, and no clr_done is issued.
